lcd1602_responder: RTL
======================

// Module: lcd1602_responder
// PURPOSE
//  Synthesizable HD44780/LCD1602 panel model. It is the receiving end of the bus that LCD1602_controller drives (rs, rw, enable, data).
//  It latches bus transfers on enable falling edges, decodes instructions, and maintains DDRAM (80 B), CGRAM (64 x 5 b), the address counter (AC) and the busy flag.
//  Monitor ports expose the display state to testbenches and to an on-chip mirror/debug path.
// PARAMETERS
//  BUSY_CYCLES        40    clk cycles busy after a normal instruction or data write
//  CLEAR_BUSY_CYCLES  1600  clk cycles busy after clear/home; must be >= 80
// PORTS
//  clk             in   1  system clock; also samples enable
//  reset           in   1  asynchronous, active-low reset
//  rs              in   1  0 = instruction/status, 1 = RAM data
//  rw              in   1  0 = write, 1 = read
//  enable          in   1  bus strobe, synchronous to clk; transfer on falling edge
//  data_i          in   8  write data
//  data_o          out  8  read data
//  busy            out  1  busy flag (BF)
//  ac              out  7  address counter
//  disp_on         out  1  display control D bit
//  cursor_on       out  1  display control C bit
//  blink_on        out  1  display control B bit
//  two_line        out  1  function set N bit
//  eight_bit       out  1  function set DL bit
//  disp_shift      out  6  display shift offset, 0..39
//  mon_dd_addr     in   7  DDRAM monitor address
//  mon_dd_data     out  8  DDRAM[mon_dd_addr], combinational
//  mon_cg_addr     in   6  CGRAM monitor address
//  mon_cg_data     out  8  {3'b0, CGRAM[mon_cg_addr]}, combinational
//  cmd_err         out  1  1-cycle pulse when a write or RAM read is attempted while busy
// BEHAVIOUR
//  Reset (async): ac=0, I/D=1, S=0, disp/cursor/blink=0, two_line=0, eight_bit=1, disp_shift=0, cmd_err=0, en_q=0.
//   After release, the FSM enters CLEAR with busy=1. CGRAM contents are undefined.
//  Edge detect: en_q <= enable; fall = en_q & ~enable. Bus fields are sampled in the fall cycle. Effects are visible next cycle.
//  FSM states:
//   IDLE  -> BUSY on an accepted write, or CLEAR on a clear instruction.
//   BUSY  counts down BUSY_CYCLES (or CLEAR_BUSY_CYCLES for home), then -> IDLE.
//   CLEAR writes 0x20 to DDRAM index 0..79 (one per cycle), then holds busy until CLEAR_BUSY_CYCLES have elapsed since entry, then -> IDLE.
//   busy = (state != IDLE).
//  Write (rw=0) while busy: the transfer is dropped and cmd_err pulses.
//  Instruction decode (rs=0), by the highest set bit:
//   1aaaaaaa  set DDRAM addr; select DDRAM.
//             In two-line mode, a[5:0] > 0x27 loads a & 0x40.
//             In one-line mode, a > 0x4F loads 0x00.
//   01aaaaaa  set CGRAM addr; select CGRAM; ac = {1'b0, a}.
//   001DNxxx  eight_bit = D, two_line = N.
//   0001SRxx  S=0: move AC by R ? +1 : -1 (DDRAM wrap rules apply).
//             S=1: disp_shift +/- 1, mod 40.
//   00001DCB  set disp_on / cursor_on / blink_on.
//   000001IS  set I/D and S.
//   0000001x  home: ac=0, disp_shift=0, select DDRAM; busy CLEAR_BUSY_CYCLES.
//   00000001  clear: ac=0, I/D=1, disp_shift=0, select DDRAM, enter CLEAR.
//   00000000  no-op; busy is not set.
//  Data write (rs=1):
//   DDRAM selected: DDRAM[idx(ac)] = data_i.
//   CGRAM selected: CGRAM[ac[5:0]] = data_i[4:0].
//   Then AC steps by I/D. If S=1, disp_shift also steps by I/D.
//  idx(ac): two-line = (ac[6] ? 40 : 0) + ac[5:0]; one-line = ac.
//  AC wrap rules:
//   two-line: 0x27+1 -> 0x40; 0x67+1 -> 0x00; 0x00-1 -> 0x67; 0x40-1 -> 0x27.
//   one-line: 0x4F <-> 0x00.
//   CGRAM: mod 64.
//  Read (rw=1):
//   data_o is combinational while enable=1 & rw=1; otherwise 8'h00.
//   rs=0 returns {busy, ac}.
//   rs=1 returns the RAM byte at ac (CGRAM zero-extended).
//   On fall of an rs=1 read: if idle, AC steps by I/D; if busy, AC does not move and cmd_err pulses.
//   Reads never set busy.
//  Simultaneous events:
//   A fall in the same cycle the BUSY/CLEAR count ends is treated as busy (dropped).
//   Reset during CLEAR restarts the clear after release.
// TESTING
//  Reset, wait out the initial CLEAR, then poll status -> data_o = 8'h00; mon_dd_data = 8'h20 for all 80 addresses.
//  Write 0x38, 0x0C, 0x01, then poll -> two_line=1, eight_bit=1, disp_on=1, cursor_on=0, busy high for 1600 cycles, then ac=0.
//  Write 0x40, then 8 data bytes 0x1F..0x18 -> mon_cg_data[0..7] = 0x1F..0x18, ac=0x08. Repeat for 0x48..0x70 plus data.
//  Two-line mode: write 0xA7 (addr 0x27), then data 'A','B' -> DDRAM idx 39='A', idx 40='B', ac=0x41.
//  Write instruction 2 cycles after a prior write -> dropped, cmd_err pulses once, state unchanged.
//  Assert reset in mid-CLEAR, then release -> busy=1, the full clear reruns, and all registers return to their reset values.

Source files
------------

// File: rtl/lcd1602_responder.sv
// HD44780 / LCD1602 panel model: the receiving end of the rs/rw/enable/data bus.
// Decodes instructions, owns DDRAM/CGRAM, the address counter and the busy flag.
module lcd1602_responder #(
    parameter int BUSY_CYCLES       = 40,
    parameter int CLEAR_BUSY_CYCLES = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       eight_bit,
    output logic [5:0] disp_shift,
    input  logic [6:0] mon_dd_addr,
    output logic [7:0] mon_dd_data,
    input  logic [5:0] mon_cg_addr,
    output logic [7:0] mon_cg_data,
    output logic       cmd_err
);
    localparam int CNT_W = $clog2(CLEAR_BUSY_CYCLES + BUSY_CYCLES + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUSY  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       clr_idx;
    logic             en_q;
    logic             fall;
    logic             id_inc;
    logic             s_shift;
    logic             cg_sel;
    logic [6:0]       dd_idx;
    logic [7:0]       ram_rd;
    logic [7:0]       ddram [80];
    logic [4:0]       cgram [64];

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up,
                                           input logic cg, input logic two);
        logic [6:0] r;
        if (cg)
            r = {1'b0, up ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        else if (two) begin
            if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            else    r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end else begin
            if (up) r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
            else    r = (a == 7'h00) ? 7'h4F : a - 7'd1;
        end
        return r;
    endfunction

    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        if (up) return (s == 6'd39) ? 6'd0 : s + 6'd1;
        else    return (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    // Out-of-window DDRAM addresses fold back to the start of their line.
    function automatic logic [6:0] dd_set(input logic [6:0] a, input logic two);
        if (two) return (a[5:0] > 6'h27) ? (a & 7'h40) : a;
        else     return (a > 7'h4F) ? 7'h00 : a;
    endfunction

    function automatic logic [6:0] dd_index(input logic [6:0] a, input logic two);
        if (two) return (a[6] ? 7'd40 : 7'd0) + {1'b0, a[5:0]};
        else     return a;
    endfunction

    assign fall   = en_q & ~enable;
    assign busy   = (state != S_IDLE);
    assign dd_idx = dd_index(ac, two_line);
    assign ram_rd = cg_sel ? {3'b000, cgram[ac[5:0]]}
                           : ((dd_idx < 7'd80) ? ddram[dd_idx] : 8'h20);
    assign data_o = (enable && rw) ? (rs ? ram_rd : {busy, ac}) : 8'h00;
    assign mon_dd_data = (mon_dd_addr < 7'd80) ? ddram[mon_dd_addr] : 8'h00;
    assign mon_cg_data = {3'b000, cgram[mon_cg_addr]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CLEAR;
            cnt        <= CNT_W'(CLEAR_BUSY_CYCLES - 1);
            clr_idx    <= 7'd0;
            en_q       <= 1'b0;
            ac         <= 7'd0;
            id_inc     <= 1'b1;
            s_shift    <= 1'b0;
            cg_sel     <= 1'b0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            two_line   <= 1'b0;
            eight_bit  <= 1'b1;
            disp_shift <= 6'd0;
            cmd_err    <= 1'b0;
        end else begin
            en_q    <= enable;
            cmd_err <= 1'b0;
            case (state)
                S_BUSY: begin
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                S_CLEAR: begin
                    if (clr_idx < 7'd80) clr_idx <= clr_idx + 7'd1;
                    if (cnt == '0) state <= S_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: ;
            endcase
            // Bus transfers only act from IDLE, so they never collide with the countdown above.
            if (fall) begin
                if (!rw) begin
                    if (state != S_IDLE) begin
                        cmd_err <= 1'b1;
                    end else if (!rs) begin
                        state <= S_BUSY;
                        cnt   <= CNT_W'(BUSY_CYCLES - 1);
                        casez (data_i)
                            8'b1???????: begin
                                ac     <= dd_set(data_i[6:0], two_line);
                                cg_sel <= 1'b0;
                            end
                            8'b01??????: begin
                                ac     <= {1'b0, data_i[5:0]};
                                cg_sel <= 1'b1;
                            end
                            8'b001?????: begin
                                eight_bit <= data_i[4];
                                two_line  <= data_i[3];
                            end
                            8'b0001????: begin
                                if (data_i[3]) disp_shift <= shift_step(disp_shift, data_i[2]);
                                else           ac <= ac_step(ac, data_i[2], cg_sel, two_line);
                            end
                            8'b00001???: begin
                                disp_on   <= data_i[2];
                                cursor_on <= data_i[1];
                                blink_on  <= data_i[0];
                            end
                            8'b000001??: begin
                                id_inc  <= data_i[1];
                                s_shift <= data_i[0];
                            end
                            8'b0000001?: begin
                                ac         <= 7'd0;
                                disp_shift <= 6'd0;
                                cg_sel     <= 1'b0;
                                cnt        <= CNT_W'(CLEAR_BUSY_CYCLES - 1);
                            end
                            8'b00000001: begin
                                ac         <= 7'd0;
                                id_inc     <= 1'b1;
                                disp_shift <= 6'd0;
                                cg_sel     <= 1'b0;
                                state      <= S_CLEAR;
                                cnt        <= CNT_W'(CLEAR_BUSY_CYCLES - 1);
                                clr_idx    <= 7'd0;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else begin
                        ac    <= ac_step(ac, id_inc, cg_sel, two_line);
                        state <= S_BUSY;
                        cnt   <= CNT_W'(BUSY_CYCLES - 1);
                        if (s_shift) disp_shift <= shift_step(disp_shift, id_inc);
                    end
                end else if (rs) begin
                    if (state != S_IDLE) cmd_err <= 1'b1;
                    else                 ac <= ac_step(ac, id_inc, cg_sel, two_line);
                end
            end
        end
    end

    // RAM contents are not reset; CLEAR has priority because data writes require IDLE.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR && clr_idx < 7'd80) begin
            ddram[clr_idx] <= 8'h20;
        end else if (fall && !rw && rs && state == S_IDLE) begin
            if (cg_sel)              cgram[ac[5:0]] <= data_i[4:0];
            else if (dd_idx < 7'd80) ddram[dd_idx]  <= data_i;
        end
    end
endmodule
